// File: rtl/opc5ls_intc.sv
// Memory-mapped interrupt controller for the OPC5LS CPU.
// It latches external requests and drives the CPU's active-low int_b.
module opc5ls_intc #(
  parameter logic [15:0] BASE_ADDR = 16'hFE00,
  parameter int unsigned NSRC      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     address,
  input  logic [15:0]     wdata,
  input  logic            rnw,
  output logic [15:0]     rdata,
  output logic            rdsel,
  input  logic [NSRC-1:0] irq,
  output logic            int_b
);

  logic            sel;
  logic            we;
  logic [NSRC-1:0] s1_q, s2_q, s3_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, edge_q;
  logic [NSRC-1:0] rise, clr, pend, active;
  logic            any_active;
  logic [3:0]      vec_idx;

  assign sel   = (address[15:2] == BASE_ADDR[15:2]);
  assign rdsel = sel;
  assign we    = sel & ~rnw;

  assign rise = s2_q & ~s3_q;
  assign clr  = (we && address[1:0] == 2'd0) ? wdata[NSRC-1:0] : '0;

  // Level sources pass s2 straight through; pending_q shadows s2 so an
  // EDGE 0->1 switch keeps the value currently seen.
  assign pend       = (edge_q & pending_q) | (~edge_q & s2_q);
  assign pending_d  = (edge_q & ((pending_q & ~clr) | rise)) | (~edge_q & s2_q);
  assign active     = pend & mask_q;
  assign any_active = |active;

  always_comb begin
    vec_idx = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 4'(i);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (address[1:0])
        2'd0: rdata[NSRC-1:0] = pend;
        2'd1: rdata[NSRC-1:0] = mask_q;
        2'd2: rdata[NSRC-1:0] = edge_q;
        default: begin
          rdata[15]  = any_active;
          rdata[3:0] = vec_idx;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      int_b     <= 1'b1;
    end else begin
      s1_q      <= irq;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      int_b     <= ~any_active;
      if (we && address[1:0] == 2'd1) mask_q <= wdata[NSRC-1:0];
      if (we && address[1:0] == 2'd2) edge_q <= wdata[NSRC-1:0];
    end
  end

endmodule
